// File: rtl/oka_pkg.sv
// Shared definitions for the OKA partial-product feeder: operand sizing helpers,
// the sequencer state type and the coefficient counter width.
package oka_pkg;

   localparam int N_DEFAULT = 14;

   // Half-operand width: one polynomial split into its even or odd coefficients.
   function automatic int oka_h(input int n);
      return n / 2;
   endfunction

   // Width of a carry-less product of two half-operands.
   function automatic int oka_pw(input int n);
      return 2 * (n / 2) - 1;
   endfunction

   function automatic int oka_cw(input int h);
      return $clog2(h);
   endfunction

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COMPUTE = 2'd1,
      DONE    = 2'd2
   } oka_state_t;

endpackage

// File: rtl/oka_gf2_serial_mult_step.sv
// One serial GF(2) shift-and-XOR accumulator: each enabled cycle folds x*x^cnt
// into the accumulator when y_bit is set. clear restarts the sum on that same step.
module oka_gf2_serial_mult_step #(
   parameter int H  = 7,
   parameter int PW = 13,
   parameter int CW = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [H-1:0]  x,
   input  logic          y_bit,
   input  logic [CW-1:0] cnt,
   input  logic          clear,
   input  logic          enable,
   output logic [PW-1:0] acc
);

   logic [PW-1:0] acc_q;
   logic [PW-1:0] acc_d;
   logic [PW-1:0] x_ext;
   logic [PW-1:0] term;

   always_comb begin
      x_ext = PW'(x);
      term  = y_bit ? (x_ext << cnt) : '0;
      acc_d = acc_q;
      if (enable) begin
         // Clearing on the first step keeps the previous result visible until a new product starts.
         acc_d = (clear ? '0 : acc_q) ^ term;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

   assign acc = acc_q;

endmodule

// File: rtl/oka_partial_product_seq.sv
// Splits two GF(2) polynomials into even/odd halves and serially forms the four
// half-products (ee, eo, oe, oo) for the overlap recombination stage.
module oka_partial_product_seq
   import oka_pkg::*;
#(
   parameter int N = N_DEFAULT
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [N-1:0]           a_in,
   input  logic [N-1:0]           b_in,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [oka_pw(N)-1:0]   pp_ee,
   output logic [oka_pw(N)-1:0]   pp_eo,
   output logic [oka_pw(N)-1:0]   pp_oe,
   output logic [oka_pw(N)-1:0]   pp_oo
);

   localparam int H  = oka_h(N);
   localparam int PW = oka_pw(N);
   localparam int CW = oka_cw(H);
   localparam logic [CW-1:0] CNT_LAST = CW'(H - 1);

   oka_state_t    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          load;
   logic          step_en;

   logic [H-1:0]  a_even, a_odd, b_even, b_odd;
   logic [H-1:0]  ae_q, ao_q, be_q, bo_q;

   generate
      for (genvar gi = 0; gi < H; gi++) begin : g_split
         assign a_even[gi] = a_in[2*gi];
         assign a_odd[gi]  = a_in[2*gi+1];
         assign b_even[gi] = b_in[2*gi];
         assign b_odd[gi]  = b_in[2*gi+1];
      end
   endgenerate

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      load    = 1'b0;
      step_en = 1'b0;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               load    = 1'b1;
               cnt_d   = '0;
               state_d = COMPUTE;
            end
         end
         COMPUTE: begin
            step_en = 1'b1;
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         ae_q    <= '0;
         ao_q    <= '0;
         be_q    <= '0;
         bo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (load) begin
            ae_q <= a_even;
            ao_q <= a_odd;
            be_q <= b_even;
            bo_q <= b_odd;
         end
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);

   // Product order: ee, eo, oe, oo -> X is the A half, Y supplies the serial bit.
   logic [H-1:0]  x_arr   [4];
   logic [H-1:0]  y_arr   [4];
   logic [PW-1:0] acc_arr [4];

   assign x_arr[0] = ae_q;  assign y_arr[0] = be_q;
   assign x_arr[1] = ae_q;  assign y_arr[1] = bo_q;
   assign x_arr[2] = ao_q;  assign y_arr[2] = be_q;
   assign x_arr[3] = ao_q;  assign y_arr[3] = bo_q;

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_step
         oka_gf2_serial_mult_step #(
            .H  (H),
            .PW (PW),
            .CW (CW)
         ) u_step (
            .clk    (clk),
            .rst    (rst),
            .x      (x_arr[gi]),
            .y_bit  (y_arr[gi][cnt_q]),
            .cnt    (cnt_q),
            .clear  (cnt_q == '0),
            .enable (step_en),
            .acc    (acc_arr[gi])
         );
      end
   endgenerate

   assign pp_ee = acc_arr[0];
   assign pp_eo = acc_arr[1];
   assign pp_oe = acc_arr[2];
   assign pp_oo = acc_arr[3];

endmodule

// File: tb/tb_oka_partial_product_seq.sv
// Randomized and directed checks of the OKA partial-product feeder against a
// carry-less multiply model built from coefficient-pair products.
module tb_oka_partial_product_seq;

   localparam int N  = 14;
   localparam int H  = N / 2;
   localparam int PW = 2 * H - 1;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [N-1:0]  a_in = '0;
   logic [N-1:0]  b_in = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [PW-1:0] pp_ee, pp_eo, pp_oe, pp_oo;

   int tests_run = 0;
   int tests_failed = 0;

   oka_partial_product_seq #(.N(N)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a_in      (a_in),
      .b_in      (b_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .pp_ee     (pp_ee),
      .pp_eo     (pp_eo),
      .pp_oe     (pp_oe),
      .pp_oo     (pp_oo)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Coefficient k of the operand (even = 0 / odd = 1 half).
   function automatic logic [H-1:0] half_of(input logic [N-1:0] v, input int odd);
      logic [H-1:0] r;
      for (int j = 0; j < H; j++) r[j] = v[2*j + odd];
      return r;
   endfunction

   // Polynomial product over GF(2): coefficient i+j collects x_i*y_j with XOR.
   function automatic logic [PW-1:0] clmul(input logic [H-1:0] x, input logic [H-1:0] y);
      logic [PW-1:0] r;
      r = '0;
      for (int i = 0; i < H; i++)
         for (int j = 0; j < H; j++)
            r[i+j] = r[i+j] ^ (x[i] & y[j]);
      return r;
   endfunction

   // Issue one operation; hold_cycles of backpressure once out_valid is seen,
   // optionally pulsing in_valid with junk operands during that window.
   task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                         input int hold_cycles, input bit junk);
      logic [PW-1:0] e_ee, e_eo, e_oe, e_oo;
      int lat;
      int waited;
      e_ee = clmul(half_of(a, 0), half_of(b, 0));
      e_eo = clmul(half_of(a, 0), half_of(b, 1));
      e_oe = clmul(half_of(a, 1), half_of(b, 0));
      e_oo = clmul(half_of(a, 1), half_of(b, 1));

      @(negedge clk);
      waited = 0;
      while (!in_ready && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      check_val("in_ready_before_op", in_ready, 1'b1);
      in_valid = 1'b1;
      a_in = a;
      b_in = b;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      a_in = $urandom();
      b_in = $urandom();
      check_val("in_ready_low_compute", in_ready, 1'b0);

      lat = 0;
      while (!out_valid && lat < 30) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check_val("latency", lat, H);
      check_val("pp_ee", pp_ee, e_ee);
      check_val("pp_eo", pp_eo, e_eo);
      check_val("pp_oe", pp_oe, e_oe);
      check_val("pp_oo", pp_oo, e_oo);

      for (int c = 0; c < hold_cycles; c++) begin
         out_ready = 1'b0;
         if (junk) begin
            in_valid = 1'b1;
            a_in = $urandom();
            b_in = $urandom();
         end
         @(posedge clk);
         #1;
         in_valid = 1'b0;
         check_val("hold_out_valid", out_valid, 1'b1);
         check_val("hold_in_ready", in_ready, 1'b0);
         check_val("hold_pp", {pp_ee, pp_eo, pp_oe, pp_oo}, {e_ee, e_eo, e_oe, e_oo});
      end

      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check_val("release_out_valid", out_valid, 1'b0);
      check_val("release_in_ready", in_ready, 1'b1);
      $display("[TB] op a=%04h b=%04h -> ee=%04h eo=%04h oe=%04h oo=%04h lat=%0d hold=%0d",
               a, b, pp_ee, pp_eo, pp_oe, pp_oo, lat, hold_cycles);
   endtask

   initial begin
      rst = 1'b1;
      #12;
      check_val("rst_in_ready", in_ready, 1'b1);
      check_val("rst_out_valid", out_valid, 1'b0);
      check_val("rst_pp", {pp_ee, pp_eo, pp_oe, pp_oo}, '0);
      @(negedge clk);
      rst = 1'b0;

      run_op(14'h0001, 14'h0001, 0, 1'b0);
      run_op(14'h0002, 14'h0002, 1, 1'b0);
      run_op(14'h0003, 14'h0003, 0, 1'b0);
      run_op(14'h3FFF, 14'h3FFF, 2, 1'b0);
      // Backpressure with ignored operand pulses.
      run_op(14'h2A5B, 14'h1C37, 5, 1'b1);

      // Abandon an operation mid-compute once cnt has reached 3.
      @(negedge clk);
      in_valid = 1'b1;
      a_in = 14'h3FFF;
      b_in = 14'h2AAA;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check_val("midrst_out_valid", out_valid, 1'b0);
      check_val("midrst_in_ready", in_ready, 1'b1);
      check_val("midrst_pp", {pp_ee, pp_eo, pp_oe, pp_oo}, '0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      $display("[TB] reset asserted mid-compute");
      run_op(14'h0003, 14'h0003, 0, 1'b0);

      for (int t = 0; t < 25; t++) begin
         logic [N-1:0] ra, rb;
         ra = N'($urandom());
         rb = N'($urandom());
         run_op(ra, rb, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
